uart_rx_ctrl: RTL and testbench

Serial receiver that sits upstream of the CPU's memory-mapped peripheral block. It turns the asynchronous `rx` pin into bytes and presents them through a valid/ready holding register. The peripheral reads that register into its UART receive-data word and raises its interrupt request from `rx_valid`. The receiver oversamples at 16x, validates the start bit, checks the stop bit, and flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM encoding, oversample constants and divider math.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // Oversample divider, truncated; callers require the result to be at least 2.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on DIV-1.
// A synchronous clear realigns the phase to the start of a frame.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 16x oversampling UART receiver with a valid/ready holding register and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY state and the parity_err port.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output state_t     fsm_state
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  if (DIV < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_ctrl: DIV must be >= 2 and PARITY_ODD must be 0 or 1");
  end

  state_t     state, state_nx;
  logic       sync1, sync2, rx_q;
  logic       fall, tick, tick_clr, s_clr, bit_pt;
  logic       shift_en, commit, frame_err_nx;
  logic [3:0] s_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {sync1, sync2, rx_q} <= 3'b111;
    end else begin
      {sync1, sync2, rx_q} <= {rx, sync1, sync2};
    end
  end

  assign fall   = rx_q && !sync2;
  assign bit_pt = tick && (s_cnt == 4'(OVERSAMPLE - 1));

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clr),
    .tick  (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_chk, par_bad, parity_err_nx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    tick_clr     = 1'b0;
    s_clr        = 1'b0;
    shift_en     = 1'b0;
    commit       = 1'b0;
    frame_err_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk       = 1'b0;
    parity_err_nx = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_nx = S_START;
          tick_clr = 1'b1;
          s_clr    = 1'b1;
        end
      end
      S_START: begin
        // Mid start bit: a high line means the falling edge was a glitch.
        if (tick && s_cnt == 4'(MID_SAMPLE)) begin
          s_clr    = 1'b1;
          state_nx = sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_pt) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_pt) begin
          par_chk  = 1'b1;
          state_nx = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_pt) begin
          if (!sync2) begin
            frame_err_nx = 1'b1;
            state_nx     = S_WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) begin
            parity_err_nx = 1'b1;
            state_nx      = S_IDLE;
          end
`endif
          else begin
            commit   = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (sync2) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_cnt   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (s_clr) begin
        s_cnt   <= '0;
        bit_cnt <= '0;
      end else begin
        if (tick) s_cnt <= s_cnt + 4'd1;
        if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) shift <= {sync2, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err_nx;
      if (tick_clr) begin
        par_bad <= 1'b0;
      end else if (par_chk) begin
        par_bad <= (^{shift, sync2}) != PARITY_ODD[0];
      end
    end
  end
`endif

  // Handshake: rx_data is offered while rx_valid is high and is consumed on any edge
  // where rx_valid && rx_ready; a commit in that same edge refills the register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_err_nx;
      overrun   <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DIV = 4, 64 clocks per bit) with a byte scoreboard.
// Build with UART_RX_PARITY_EN defined to include the parity scenario.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int COMMIT_OFS = 675;
`else
  localparam int COMMIT_OFS = 611;
`endif

  logic       clk = 1'b0;
  logic       reset, rx, rx_ready;
  logic       rx_valid, busy, frame_err, overrun;
  logic [7:0] rx_data;
  state_t     fsm_state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  int checks = 0, errors = 0, cyc = 0;
  int frame_err_cnt = 0, overrun_cnt = 0, parity_err_cnt = 0;
  int valid_rise_cnt = 0, valid_rise_cyc = 0, frame_start_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (25_000),
    .PARITY_ODD (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) frame_err_cnt++;
      if (overrun) overrun_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) parity_err_cnt++;
`endif
      if (rx_valid && !prev_valid) begin
        valid_rise_cnt++;
        valid_rise_cyc = cyc;
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
        end else begin
          check("rx_data_pop", rx_data, exp_q.pop_front());
        end
      end
    end
    prev_valid = rx_valid;
  end

  // drivers
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    wait_clk(1);
    frame_start_cyc = cyc;
    rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_clk(BIT_CLKS);
`endif
    rx = stop;
    wait_clk(BIT_CLKS);
  endtask

  task automatic drain();
    wait_clk(1);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    @(negedge clk);
    check("valid_cleared", rx_valid, 1'b0);
  endtask

  // directed scenarios
  initial begin
    int v0, fe0, ov0, lat;
    bit ok;
    reset = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    wait_clk(5);
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_state", fsm_state, S_IDLE);
    wait_clk(1);
    reset = 1'b1;
    wait_clk(10);

    // basic receive
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    @(negedge clk);
    lat = valid_rise_cyc - frame_start_cyc;
    check("basic_valid", rx_valid, 1'b1);
    check("basic_latency_window", (lat >= 590 && lat <= 660), 1'b1);
    check("basic_frame_err", frame_err_cnt, 0);
    check("basic_busy_low", busy, 1'b0);
    drain();

    // false start
    v0 = valid_rise_cnt;
    wait_clk(20);
    rx = 1'b0;
    wait_clk(10);
    @(negedge clk);
    check("glitch_busy", busy, 1'b1);
    wait_clk(10);
    rx = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("glitch_busy_cleared", ok, 1'b1);
    wait_clk(100);
    @(negedge clk);
    check("glitch_no_valid", valid_rise_cnt, v0);
    check("glitch_no_frame_err", frame_err_cnt, 0);
    check("glitch_no_overrun", overrun_cnt, 0);

    // framing error, line held low afterwards
    fe0 = frame_err_cnt;
    send_frame(8'hA3, 1'b0);
    wait_clk(100);
    @(negedge clk);
    check("ferr_busy_hold", busy, 1'b1);
    check("ferr_state_wait", fsm_state, S_WAIT_IDLE);
    wait_clk(100);
    @(negedge clk);
    check("ferr_single_pulse", frame_err_cnt, fe0 + 1);
    check("ferr_no_valid", rx_valid, 1'b0);
    rx = 1'b1;
    wait_clk(10);
    @(negedge clk);
    check("ferr_busy_released", busy, 1'b0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    @(negedge clk);
    check("ferr_recover_valid", rx_valid, 1'b1);
    drain();

    // overrun with consumer stalled
    ov0 = overrun_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_clk(20);
    send_frame(8'h34, 1'b1);
    wait_clk(5);
    @(negedge clk);
    check("ovr_pulse_count", overrun_cnt, ov0 + 1);
    check("ovr_data_kept", rx_data, 8'h12);
    drain();

    // accept on the commit edge: no overrun
    ov0 = overrun_cnt;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_clk(20);
    exp_q.push_back(8'h34);
    fork
      send_frame(8'h34, 1'b1);
      begin
        wait_clk(1);
        wait_clk(COMMIT_OFS - 1);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("same_cycle_no_overrun", overrun_cnt, ov0);
    check("same_cycle_new_data", rx_data, 8'h34);
    check("same_cycle_valid", rx_valid, 1'b1);
    drain();

    // reset mid-frame with an unread byte held
    send_frame(8'h5A, 1'b1);
    wait_clk(20);
    rx = 1'b0;
    wait_clk(BIT_CLKS);
    rx = 1'b1;
    wait_clk(3 * BIT_CLKS + 20);
    @(negedge clk);
    check("midframe_busy", busy, 1'b1);
    wait_clk(1);
    reset = 1'b0;
    wait_clk(2);
    @(negedge clk);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_flags", {frame_err, overrun}, 2'b00);
    wait_clk(1);
    reset = 1'b1;
    wait_clk(BIT_CLKS * 8);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    @(negedge clk);
    check("post_rst_valid", rx_valid, 1'b1);
    drain();

`ifdef UART_RX_PARITY_EN
    // even parity: 0x01 needs parity bit 1
    par_flip = 1'b1;
    send_frame(8'h01, 1'b1);
    wait_clk(5);
    @(negedge clk);
    check("par_err_pulse", parity_err_cnt, 1);
    check("par_err_no_valid", rx_valid, 1'b0);
    par_flip = 1'b0;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    @(negedge clk);
    check("par_ok_valid", rx_valid, 1'b1);
    drain();
`endif

    // final report
    wait_clk(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
